// File: rtl/pe_packet_tx.sv
// pe_packet_tx: FIFO-buffered flit transmitter driving a router PE port with 4-phase bundled data.
// Define PE_PACKET_TX_STATS_EN to add the sent_cnt completed-handshake counter.
module pe_packet_tx #(
    parameter int WIDTH      = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_dir,
    input  logic [2:0]       in_hop,
    input  logic [6:0]       in_payload,
    output logic             req,
    input  logic             ack,
    output logic [0:WIDTH-1] data,
    output logic             busy
`ifdef PE_PACKET_TX_STATS_EN
    ,
    output logic [15:0]      sent_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SETUP_CYC + 1);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO} state_t;

    state_t           state;
    logic [0:WIDTH-1] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [CW-1:0]    setup_cnt;
    logic             ack_m, ack_s;
    logic             push, pop;
    logic [0:WIDTH-1] flit;

    // A zero hop count would be dropped by the router, so it is promoted to one hop.
    assign flit     = {in_dir, (in_hop == 3'b000) ? 3'b001 : in_hop, 3'b100, in_payload};
    assign in_ready = rst_n && (count != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign busy     = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= flit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // ack comes from the router's clock-free handshake logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req       <= 1'b0;
            data      <= '0;
            setup_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    data      <= mem[rd_ptr];
                    setup_cnt <= CW'(SETUP_CYC);
                    state     <= SETUP;
                end
                SETUP: if (setup_cnt > CW'(1)) begin
                    setup_cnt <= setup_cnt - 1'b1;
                end else if (!ack_s) begin
                    setup_cnt <= '0;
                    req       <= 1'b1;
                    state     <= WAIT_ACK_HI;
                end
                WAIT_ACK_HI: if (ack_s) begin
                    req   <= 1'b0;
                    state <= WAIT_ACK_LO;
                end
                WAIT_ACK_LO: if (!ack_s)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PE_PACKET_TX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sent_cnt <= '0;
        else if (state == WAIT_ACK_HI && ack_s)
            sent_cnt <= sent_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pe_packet_tx.sv
// tb_pe_packet_tx: scoreboard bench for pe_packet_tx with a 4-phase responder and bundling monitor.
// Build with PE_PACKET_TX_STATS_EN defined to also check sent_cnt.
module tb_pe_packet_tx;
    localparam int SC = 3;

    logic        clk = 0, rst_n = 1, in_valid = 0, ack = 0;
    logic        in_ready, req, busy;
    logic [1:0]  in_dir = '0;
    logic [2:0]  in_hop = '0;
    logic [6:0]  in_payload = '0;
    logic [0:14] data;
`ifdef PE_PACKET_TX_STATS_EN
    logic [15:0] sent_cnt;
`endif

    int checks = 0, fails = 0;
    int rx_cnt = 0, rx_base = 0, viol = 0, req_rises = 0, cyc = 0, load_cyc = 0;
    bit hold_ack = 0;
    logic [14:0] sb[$];
    logic [0:14] prev_data = '0;
    logic        prev_req = 0, prev_ack = 0;

    typedef struct {
        logic [1:0]  dir;
        logic [2:0]  hop;
        logic [6:0]  pay;
        logic [14:0] exp;
    } vec_t;
    vec_t tbl[5];

    pe_packet_tx #(.WIDTH(15), .FIFO_DEPTH(4), .SETUP_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_dir(in_dir), .in_hop(in_hop), .in_payload(in_payload),
        .req(req), .ack(ack), .data(data), .busy(busy)
`ifdef PE_PACKET_TX_STATS_EN
        , .sent_cnt(sent_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] flit_of(input logic [1:0] d, input logic [2:0] h, input logic [6:0] p);
        return {d, (h == 3'b000) ? 3'b001 : h, 3'b100, p};
    endfunction

    // Zero-delay 4-phase responder, scoreboard sink and bundling monitor.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            ack = 0;
            prev_data = data;
            prev_req = 0;
            prev_ack = 0;
        end else begin
            if (data !== prev_data) begin
                if (prev_req || prev_ack) viol++;
                load_cyc = cyc;
            end
            if (req && !prev_req) begin
                req_rises++;
                if (ack) viol++;
                check("setup_gap", cyc - load_cyc, SC);
            end
            if (req && !ack && !hold_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_flit: got %h required none", data);
                end else begin
                    check("flit", data, sb.pop_front());
                end
                ack = 1;
                rx_cnt++;
            end else if (!req && ack) begin
                ack = 0;
            end
            prev_data = data;
            prev_req = req;
            prev_ack = ack;
        end
    end

    task automatic send(input logic [1:0] d, input logic [2:0] h, input logic [6:0] p, input logic [14:0] exp);
        int n = 0;
        @(negedge clk);
        in_dir = d;
        in_hop = h;
        in_payload = p;
        in_valid = 1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("push_timeout", 0, 1);
        else sb.push_back(exp);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_idle(input int target);
        int n = 0;
        while ((busy || req || ack || rx_cnt != target) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_rx", rx_cnt, target);
        check("busy_idle", busy, 0);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] e;
        int n;
        tbl[0] = '{2'b10, 3'b000, 7'h7F, 15'b10_001_100_1111111};
        tbl[1] = '{2'b11, 3'b111, 7'h00, 15'b11_111_100_0000000};
        tbl[2] = '{2'b00, 3'b000, 7'h2A, 15'b00_001_100_0101010};
        tbl[3] = '{2'b01, 3'b101, 7'h55, 15'b01_101_100_1010101};
        tbl[4] = '{2'b00, 3'b010, 7'h01, 15'b00_010_100_0000001};

        #1 rst_n = 0;
        #2;
        check("rst_req", req, 0);
        check("rst_data", data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1 check("post_rst_in_ready", in_ready, 1);

        // Single packet with cycle-exact handshake timing.
        n = req_rises;
        send(2'b01, 3'b011, 7'h05, 15'b01_011_100_0000101);
        @(posedge clk); #1;
        check("load_data", data, 15'b01_011_100_0000101);
        check("load_req_low", req, 0);
        repeat (SC) @(posedge clk);
        #1 check("req_rise", req, 1);
        repeat (2) @(posedge clk);
        #1 check("req_held_sync", req, 1);
        @(posedge clk);
        #1 check("req_fall", req, 0);
        repeat (2) @(posedge clk);
        #1 check("busy_wait_lo", busy, 1);
        @(posedge clk);
        #1 check("busy_done", busy, 0);
        wait_idle(1);
        check("one_req_cycle", req_rises - n, 1);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].dir, tbl[i].hop, tbl[i].pay, tbl[i].exp);
            wait_idle(rx_cnt + ((sb.size() != 0 || req) ? 1 : 0));
        end
        check("table_rx", rx_cnt, 6);

        // Backpressure: first flit stalls in the handshake, four more fill the FIFO.
        hold_ack = 1;
        n = rx_cnt;
        for (int k = 0; k < 5; k++) begin
            send(2'b00, 3'b001, 7'(k), flit_of(2'b00, 3'b001, 7'(k)));
            check("bp_in_ready", in_ready, (k < 4) ? 1 : 0);
        end
        repeat (20) @(posedge clk);
        #2;
        check("bp_req_held", req, 1);
        check("bp_full", in_ready, 0);
        check("bp_none_rx", rx_cnt, n);
        hold_ack = 0;
        wait_idle(n + 5);

        for (int i = 0; i < 100; i++) begin
            logic [1:0] d;
            logic [2:0] h;
            d = 2'($urandom_range(3));
            h = 3'($urandom_range(7));
            send(d, h, 7'(i), flit_of(d, h, 7'(i)));
        end
        wait_idle(n + 105);
        check("bundling_violations", viol, 0);

        // Reset while the router has not yet acknowledged.
        hold_ack = 1;
        send(2'b11, 3'b010, 7'h33, flit_of(2'b11, 3'b010, 7'h33));
        n = 0;
        while (!req && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("req_before_reset", req, 1);
        #2 rst_n = 0;
        sb.delete();
        #1;
        check("mid_rst_req", req, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        hold_ack = 0;
        rx_base = rx_cnt;
        #1 check("mid_rst_in_ready", in_ready, 1);
        send(2'b01, 3'b100, 7'h11, 15'b01_100_100_0010001);
        wait_idle(rx_base + 1);
`ifdef PE_PACKET_TX_STATS_EN
        check("sent_cnt", sent_cnt, 32'(rx_cnt - rx_base));
`endif
        check("final_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
